// File: rtl/ioctl_loader_pkg.sv
// Shared types and constants for the ioctl-to-PC88 loader bridge.
// The FIFO entry address field is sized by LDR_ADDR_W; keep the bridge's ADDR_W equal to it.
package ioctl_loader_pkg;

  localparam int          LDR_ADDR_W = 19;
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP,
    DONE
  } ldr_state_e;

  typedef struct packed {
    logic [LDR_ADDR_W-1:0] adr;
    logic [7:0]            dat;
  } fifo_entry_t;

  // CRC-16/CCITT over one byte, MSB first, no reflection.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] dat);
    logic [15:0] c;
    c = crc ^ {dat, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/ldr_fifo.sv
// Small synchronous FIFO of {addr,data} entries with first-word-fall-through head.
// DEPTH must be a power of two so the pointers wrap naturally.
module ldr_fifo
  import ioctl_loader_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  fifo_entry_t      din,
  output fifo_entry_t      head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  fifo_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // NOTE: storage has no reset; an entry is only read after it was written, and reset clears the pointers.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ioctl_loader_bridge.sv
// Buffers HPS ioctl download bytes and replays them to the PC88 loader with a req/ack handshake.
// Define IOCTL_LOADER_CRC_EN to compute a CRC-16/CCITT of accepted bytes on crc; otherwise crc is 0.
module ioctl_loader_bridge
  import ioctl_loader_pkg::*;
#(
  parameter int ADDR_W     = LDR_ADDR_W,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYC    = 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] ldr_adr,
  output logic [7:0]        ldr_wdat,
  output logic              ldr_oe,
  output logic              ldr_wr,
  input  logic              ldr_ack,
  output logic              ldr_done,
  output logic              range_err,
  output logic              ovf_err,
  output logic [15:0]       crc
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  ldr_state_e       state_q, state_d;
  logic             old_dl, old_ack;
  logic             dl_rise, ack_rise;
  logic             accept, range_bad, push, pop;
  logic [GAP_W-1:0] gap_cnt;
  fifo_entry_t      din, head;
  logic [CNT_W-1:0] count;
  logic             full, empty;

  assign dl_rise   = ioctl_download & ~old_dl;
  assign ack_rise  = ldr_ack & ~old_ack;
  assign accept    = ioctl_wr & ioctl_download & ~ldr_done;
  assign range_bad = |ioctl_addr[24:ADDR_W];
  assign push      = accept & ~range_bad & ~full;
  assign pop       = (state_q == REQ) & ack_rise;
  assign din       = '{adr: ioctl_addr[ADDR_W-1:0], dat: ioctl_dout};
  assign ldr_wr    = (state_q == REQ);

  ldr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .din     (din),
    .head    (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // NOTE: next state gets its default before the case, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!empty)                        state_d = REQ;
        else if (!ioctl_download && ldr_oe) state_d = DONE;
      end
      REQ:     if (ack_rise) state_d = GAP;
      GAP:     if (gap_cnt == GAP_W'(GAP_CYC - 1)) state_d = IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      old_dl     <= 1'b0;
      old_ack    <= 1'b0;
      gap_cnt    <= '0;
      ldr_adr    <= '0;
      ldr_wdat   <= '0;
      ldr_oe     <= 1'b0;
      ldr_done   <= 1'b0;
      range_err  <= 1'b0;
      ovf_err    <= 1'b0;
      ioctl_wait <= 1'b0;
    end else begin
      state_q    <= state_d;
      old_dl     <= ioctl_download;
      old_ack    <= ldr_ack;
      gap_cnt    <= (state_q == GAP) ? gap_cnt + GAP_W'(1) : '0;
      ioctl_wait <= (count >= CNT_W'(FIFO_DEPTH - 1));
      if (state_q == IDLE && state_d == REQ) begin
        ldr_adr  <= head.adr;
        ldr_wdat <= head.dat;
      end
      if (state_q == DONE) begin
        ldr_done <= 1'b1;
        ldr_oe   <= 1'b0;
      end
      // A new download wins over a stale completion; drops in the same cycle belong to it.
      if (dl_rise) begin
        ldr_done  <= 1'b0;
        range_err <= 1'b0;
        ovf_err   <= 1'b0;
        ldr_oe    <= 1'b1;
      end
      if (accept && range_bad)          range_err <= 1'b1;
      if (accept && !range_bad && full) ovf_err   <= 1'b1;
    end
  end

`ifdef IOCTL_LOADER_CRC_EN
  logic [15:0] crc_q;

  always_ff @(posedge clk_sys) begin
    if (reset)        crc_q <= CRC16_INIT;
    else if (push)    crc_q <= crc16_byte(dl_rise ? CRC16_INIT : crc_q, ioctl_dout);
    else if (dl_rise) crc_q <= CRC16_INIT;
  end

  assign crc = crc_q;
`else
  assign crc = 16'h0000;
`endif

endmodule
